// File: rtl/screen_buffer_ctrl.sv
// 32x32 display store: the CPU edits a back buffer, the video path reads a front buffer one row at a time.
// PUSH copies back to front one row per cycle once vblank is seen; video reads always win the front port and stall the copy.
module screen_buffer_ctrl #(
    parameter int ROWS   = 32,
    parameter int COLS   = 32,
    parameter int FCNT_W = 8
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_cmd_valid,
    output logic              O_cmd_ready,
    input  logic [2:0]        I_cmd_op,
    input  logic [4:0]        I_x,
    input  logic [4:0]        I_y,
    output logic              O_load_valid,
    output logic              O_load_data,
    input  logic              I_vblank,
    input  logic              I_vid_req,
    input  logic [4:0]        I_vid_row,
    output logic              O_vid_valid,
    output logic [COLS-1:0]   O_vid_data,
    output logic              O_busy,
    output logic [FCNT_W-1:0] O_frame_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_VB, PUSH, CLEAR} state_t;

    localparam logic [2:0] OP_SET   = 3'd1;
    localparam logic [2:0] OP_CLR   = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_PUSH  = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [4:0]      cnt;
    logic [COLS-1:0] back  [ROWS];
    logic [COLS-1:0] front [ROWS];
    logic            accept;
    logic            copy_en;
    logic            last_row;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = I_cmd_valid && (state == IDLE);
        copy_en   = (state == PUSH) && !I_vid_req;
        last_row  = (cnt == LAST_ROW);
        case (state)
            IDLE: begin
                if (accept && (I_cmd_op == OP_PUSH)) begin
                    state_nxt = WAIT_VB;
                end else if (accept && (I_cmd_op == OP_CLEAR)) begin
                    state_nxt = CLEAR;
                end
            end
            WAIT_VB: begin
                if (I_vblank) begin
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                // vblank is only sampled on entry; a started copy always runs to the last row
                if (copy_en && last_row) begin
                    state_nxt = IDLE;
                end
            end
            CLEAR: begin
                if (last_row) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign O_cmd_ready = (state == IDLE);
    assign O_busy      = (state != IDLE);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt         <= '0;
            O_frame_cnt <= '0;
        end else begin
            if ((accept && (I_cmd_op == OP_CLEAR)) || ((state == WAIT_VB) && I_vblank)) begin
                cnt <= '0;
            end else if (copy_en || (state == CLEAR)) begin
                cnt <= cnt + 5'd1;
            end
            if (copy_en && last_row) begin
                O_frame_cnt <= O_frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                back[r]  <= '0;
                front[r] <= '0;
            end
        end else begin
            if (accept) begin
                case (I_cmd_op)
                    OP_SET:  back[I_y][I_x] <= 1'b1;
                    OP_CLR:  back[I_y][I_x] <= 1'b0;
                    default: ;
                endcase
            end
            if (state == CLEAR) begin
                back[cnt] <= '0;
            end
            if (copy_en) begin
                front[cnt] <= back[cnt];
            end
        end
    end

    // Reads sample the registered arrays, so a same-cycle copy of the read row returns the old contents
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_load_valid <= 1'b0;
            O_load_data  <= 1'b0;
            O_vid_valid  <= 1'b0;
            O_vid_data   <= '0;
        end else begin
            O_load_valid <= accept && (I_cmd_op == OP_LOAD);
            if (accept && (I_cmd_op == OP_LOAD)) begin
                O_load_data <= back[I_y][I_x];
            end
            O_vid_valid <= I_vid_req;
            if (I_vid_req) begin
                O_vid_data <= front[I_vid_row];
            end
        end
    end

endmodule

// File: doc/screen_buffer_ctrl.md
Name: screen_buffer_ctrl

Overview:
Owns the 32x32 monochrome display store shared by the CPU and the HDMI video path. It holds a back buffer that the CPU edits through a command handshake, and a front buffer that the video side reads one row at a time. On a PUSH command it copies the back buffer into the front buffer during vertical blanking, which gives tear-free frames. Each cycle it arbitrates the single front-buffer port between video reads, which have priority, and push copies.

Parameters:
ROWS, 32, number of display rows; fixes the row index width at 5 bits.
COLS, 32, pixels per row; equals the video row data width.
FCNT_W, 8, width of the completed-frame counter.

Ports:
I_clk  in  1  system clock
I_rst_n  in  1  asynchronous active-low reset
I_cmd_valid  in  1  CPU command valid
O_cmd_ready  out  1  command accepted when high together with I_cmd_valid
I_cmd_op  in  3  command: 0 NOP, 1 SET, 2 CLR, 3 LOAD, 4 PUSH, 5 CLEAR, 6-7 treated as NOP
I_x  in  5  pixel column, bit index within a row
I_y  in  5  pixel row
O_load_valid  out  1  one-cycle pulse carrying the LOAD result
O_load_data  out  1  pixel value returned by LOAD
I_vblank  in  1  video vertical-blank level
I_vid_req  in  1  video row read request
I_vid_row  in  5  row index to read
O_vid_valid  out  1  read data valid, one cycle after the request
O_vid_data  out  32  front-buffer row, bit x = pixel x
O_busy  out  1  high in any state other than IDLE
O_frame_cnt  out  FCNT_W  number of completed pushes, wraps

Behaviour:
- Reset (asynchronous, I_rst_n=0):
  - both buffers cleared to all zeros; FSM in IDLE; row counter 0.
  - O_cmd_ready=1, O_load_valid=0, O_load_data=0, O_vid_valid=0, O_vid_data=0, O_busy=0, O_frame_cnt=0.
  - Reset mid-PUSH or mid-CLEAR aborts the operation; the frame counter does not increment.
- FSM states: IDLE, WAIT_VB, PUSH, CLEAR. O_cmd_ready=1 only in IDLE.
- IDLE: a command is accepted on I_cmd_valid & O_cmd_ready.
  - SET: back[y][x] <= 1 at the accepting edge.
  - CLR: back[y][x] <= 0 at the accepting edge.
  - LOAD: O_load_valid=1 and O_load_data=back[y][x] in the next cycle. The value reflects every write accepted in earlier cycles, so SET in cycle N followed by LOAD in cycle N+1 returns 1.
  - PUSH: go to WAIT_VB.
  - CLEAR: row counter <= 0; go to CLEAR.
  - NOP and reserved ops: no effect.
- WAIT_VB: stay until I_vblank=1. Then row counter <= 0 and go to PUSH; the first copy is possible in that same vblank cycle+1.
- PUSH: each cycle with I_vid_req=0:
  - front[cnt] <= back[cnt]; cnt increments.
  - After row 31 is written, go to IDLE and increment O_frame_cnt modulo 2^FCNT_W (255 -> 0).
- PUSH with I_vid_req=1: the video read wins, no copy happens and cnt holds. PUSH therefore lasts 32 + (number of stalled cycles).
- PUSH when I_vblank drops mid-copy: the copy continues to completion; it is not re-gated.
- CLEAR: back[cnt] <= 0 each cycle; exits to IDLE after row 31 (exactly 32 cycles). The front buffer and O_frame_cnt are unaffected.
- Video read:
  - I_vid_req is served in every state: O_vid_valid=1 and O_vid_data=front[I_vid_row] on the next cycle.
  - If the requested row is copied in the same cycle, the read returns the old row. Because video has priority, this case only arises as an ordering rule in the RTL.
  - O_vid_data holds its last value while O_vid_valid=0.
- Back-buffer commands are never applied outside IDLE; an asserted I_cmd_valid simply waits.
- O_busy = (state != IDLE).

Test Plan:
1. Reset, then SET (x=3,y=5) followed by LOAD (3,5) -> O_load_valid pulse with data=1 one cycle after the LOAD is accepted. Then CLR (3,5) and LOAD -> data=0.
2. SET (0,0) and (31,31), PUSH with I_vblank=0 for 10 cycles -> state stays WAIT_VB, O_cmd_ready=0. Raise vblank -> after 32 copy cycles O_busy=0 and O_frame_cnt=1; video reads of row 0 and row 31 return 0x00000001 and 0x80000000.
3. During PUSH, hold I_vid_req=1 for 4 cycles at the copy of row 10 -> PUSH completes in 36 cycles. Each read returns its front row with 1-cycle latency.
4. Fill the back buffer, issue CLEAR -> O_busy high for exactly 32 cycles. Every LOAD afterwards returns 0; the front buffer is unchanged.
5. Perform 256 pushes -> O_frame_cnt wraps from 255 to 0.
6. Assert I_rst_n=0 at row 15 of a PUSH -> immediately all outputs are at reset values and reads return 0; after release O_frame_cnt=0 and the FSM is in IDLE.
